// File: rtl/axilite_reg_wr_if.sv
// AXI-Lite write channels (AW/W/B) plus the register-side write strobe of axilite_reg_wr.
interface axilite_reg_wr_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 40,
    parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
);
    logic [ADDR_WIDTH-1:0] s_axil_awaddr;
    logic [2:0]            s_axil_awprot;
    logic                  s_axil_awvalid;
    logic                  s_axil_awready;
    logic [DATA_WIDTH-1:0] s_axil_wdata;
    logic [STRB_WIDTH-1:0] s_axil_wstrb;
    logic                  s_axil_wvalid;
    logic                  s_axil_wready;
    logic [1:0]            s_axil_bresp;
    logic                  s_axil_bvalid;
    logic                  s_axil_bready;
    logic [ADDR_WIDTH-1:0] reg_wr_addr;
    logic [DATA_WIDTH-1:0] reg_wr_data;
    logic [STRB_WIDTH-1:0] reg_wr_strb;
    logic                  reg_wr_en;
    logic                  reg_wr_wait;
    logic                  reg_wr_ack;

    modport slave (
        input  s_axil_awaddr, s_axil_awprot, s_axil_awvalid,
        input  s_axil_wdata, s_axil_wstrb, s_axil_wvalid,
        input  s_axil_bready,
        input  reg_wr_wait, reg_wr_ack,
        output s_axil_awready, s_axil_wready, s_axil_bresp, s_axil_bvalid,
        output reg_wr_addr, reg_wr_data, reg_wr_strb, reg_wr_en
    );

    modport master (
        output s_axil_awaddr, s_axil_awprot, s_axil_awvalid,
        output s_axil_wdata, s_axil_wstrb, s_axil_wvalid,
        output s_axil_bready,
        output reg_wr_wait, reg_wr_ack,
        input  s_axil_awready, s_axil_wready, s_axil_bresp, s_axil_bvalid,
        input  reg_wr_addr, reg_wr_data, reg_wr_strb, reg_wr_en
    );
endinterface

// File: rtl/axilite_reg_wr.sv
// AXI-Lite write slave driving a single-beat register write with ack/wait/timeout completion.
// Optional macro AXIL_WR_TIMEOUT_SLVERR_EN: unacknowledged timeouts answer SLVERR.
module axilite_reg_wr #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 40,
    parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
    parameter int unsigned TIMEOUT    = 2
) (
    input logic             clk,
    input logic             rst,
    axilite_reg_wr_if.slave bus
);
    localparam int unsigned CntW = $clog2(TIMEOUT);
    localparam logic [CntW-1:0] CntLoad = CntW'(TIMEOUT - 1);

    logic                  aw_held_q, aw_held_d;
    logic                  w_held_q, w_held_d;
    logic                  bvalid_q, bvalid_d;
    logic                  en_q, en_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [STRB_WIDTH-1:0] strb_q, strb_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  aw_hs, w_hs, done;

    logic unused_awprot;
    assign unused_awprot = ^bus.s_axil_awprot;

    always_comb begin
        aw_hs     = bus.s_axil_awvalid && !aw_held_q;
        w_hs      = bus.s_axil_wvalid && !w_held_q;
        done      = en_q && (bus.reg_wr_ack || (cnt_q == '0));
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        addr_d    = addr_q;
        data_d    = data_q;
        strb_d    = strb_q;
        bvalid_d  = bvalid_q;
        cnt_d     = cnt_q;

        // Channels are held only while a write is outstanding, so capture and completion
        // never coincide on the same channel.
        if (done) begin
            aw_held_d = 1'b0;
        end else if (aw_hs) begin
            aw_held_d = 1'b1;
            addr_d    = bus.s_axil_awaddr;
        end

        if (done) begin
            w_held_d = 1'b0;
        end else if (w_hs) begin
            w_held_d = 1'b1;
            data_d   = bus.s_axil_wdata;
            strb_d   = bus.s_axil_wstrb;
        end

        if (done) begin
            bvalid_d = 1'b1;
        end else if (bvalid_q && bus.s_axil_bready) begin
            bvalid_d = 1'b0;
        end

        // Holding off en while B is pending keeps at most one response outstanding.
        en_d = aw_held_d && w_held_d && !bvalid_d;

        if (!en_q) begin
            cnt_d = CntLoad;
        end else if (!bus.reg_wr_wait && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            en_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            strb_q    <= '0;
            cnt_q     <= '0;
        end else begin
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            bvalid_q  <= bvalid_d;
            en_q      <= en_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            strb_q    <= strb_d;
            cnt_q     <= cnt_d;
        end
    end

`ifdef AXIL_WR_TIMEOUT_SLVERR_EN
    logic [1:0] bresp_q, bresp_d;

    always_comb begin
        bresp_d = bresp_q;
        if (done) begin
            bresp_d = bus.reg_wr_ack ? 2'b00 : 2'b10;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bresp_q <= 2'b00;
        end else begin
            bresp_q <= bresp_d;
        end
    end

    assign bus.s_axil_bresp = bresp_q;
`else
    assign bus.s_axil_bresp = 2'b00;
`endif

    assign bus.s_axil_awready = !aw_held_q;
    assign bus.s_axil_wready  = !w_held_q;
    assign bus.s_axil_bvalid  = bvalid_q;
    assign bus.reg_wr_en      = en_q;
    assign bus.reg_wr_addr    = addr_q;
    assign bus.reg_wr_data    = data_q;
    assign bus.reg_wr_strb    = strb_q;
endmodule

// File: tb/tb_axilite_reg_wr.sv
// Randomized scoreboard bench for axilite_reg_wr: writes, register-side windows and B responses.
module tb_axilite_reg_wr;
    localparam int unsigned DW  = 32;
    localparam int unsigned AW  = 40;
    localparam int unsigned SW  = 4;
    localparam int unsigned TO  = 4;
    localparam int unsigned NWR = 60;
`ifdef AXIL_WR_TIMEOUT_SLVERR_EN
    localparam logic [1:0] TimeoutResp = 2'b10;
`else
    localparam logic [1:0] TimeoutResp = 2'b00;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axilite_reg_wr_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .STRB_WIDTH(SW)) bus ();

    axilite_reg_wr #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .STRB_WIDTH(SW),
        .TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [SW-1:0] strb;
    } wr_t;

    typedef struct packed {
        int unsigned len;
        logic [1:0]  resp;
    } win_t;

    wr_t        exp_wr[$];
    win_t       exp_win[$];
    logic [1:0] exp_b[$];
    int checks = 0;
    int errors = 0;
    bit force_to = 1'b0;
    bit in_win = 1'b0;
    int unsigned win_len = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic flag(input string msg);
        checks++;
        errors++;
        $display("FAIL %s", msg);
    endtask

    // Register-side responder; the expected window length and response come from the policy.
    int idx = 0;
    int ack_at = 0;
    int wait_n = 0;
    always @(posedge clk) begin
        #1;
        if (bus.reg_wr_en) begin
            if (idx == 0) begin
                int last;
                win_t e;
                wait_n = ($urandom_range(0, 3) == 0) ? 10 : int'($urandom_range(0, 3));
                last   = wait_n + int'(TO) - 1;
                ack_at = force_to ? 1000 : int'($urandom_range(0, last + 3));
                e.len  = (ack_at <= last) ? ack_at + 1 : last + 1;
                e.resp = (ack_at <= last) ? 2'b00 : TimeoutResp;
                exp_win.push_back(e);
            end
            bus.reg_wr_ack  = (idx == ack_at);
            bus.reg_wr_wait = (idx < wait_n);
            idx++;
        end else begin
            idx = 0;
            bus.reg_wr_ack  = 1'($urandom_range(0, 1));
            bus.reg_wr_wait = 1'($urandom_range(0, 1));
        end
    end

    always @(posedge clk) begin
        #1;
        bus.s_axil_bready = ($urandom_range(0, 3) != 0);
    end

    // Monitor: register writes, window lengths and B responses against the queues.
    always @(negedge clk) begin
        if (rst) begin
            in_win  = 1'b0;
            win_len = 0;
        end else begin
            if (bus.reg_wr_en) begin
                if (!in_win) begin
                    in_win  = 1'b1;
                    win_len = 0;
                    if (exp_wr.size() == 0) begin
                        flag("reg_wr_en with no write issued");
                    end else begin
                        wr_t w;
                        w = exp_wr.pop_front();
                        check("reg_wr_addr", 64'(bus.reg_wr_addr), 64'(w.addr));
                        check("reg_wr_data", 64'(bus.reg_wr_data), 64'(w.data));
                        check("reg_wr_strb", 64'(bus.reg_wr_strb), 64'(w.strb));
                    end
                end
                win_len++;
            end else if (in_win) begin
                in_win = 1'b0;
                if (exp_win.size() == 0) begin
                    flag("reg_wr_en window with no expectation");
                end else begin
                    win_t e;
                    e = exp_win.pop_front();
                    check("reg_wr_en length", 64'(win_len), 64'(e.len));
                    exp_b.push_back(e.resp);
                end
            end
            if (bus.reg_wr_en && bus.s_axil_bvalid) begin
                flag("reg_wr_en while B outstanding");
            end
            if (bus.s_axil_bvalid) begin
                if (exp_b.size() == 0) begin
                    flag("stray bvalid");
                end else begin
                    check("bresp", 64'(bus.s_axil_bresp), 64'(exp_b[0]));
                    if (bus.s_axil_bready) begin
                        void'(exp_b.pop_front());
                    end
                end
            end
        end
    end

    task automatic send_aw(input logic [AW-1:0] a, input int d);
        bit hs;
        int n;
        repeat (d) @(posedge clk);
        if (d != 0) #1;
        bus.s_axil_awaddr  = a;
        bus.s_axil_awprot  = 3'($urandom_range(0, 7));
        bus.s_axil_awvalid = 1'b1;
        hs = 1'b0;
        n  = 0;
        while (!hs && n < 200) begin
            @(negedge clk);
            hs = bus.s_axil_awready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!hs) flag("AW handshake timeout");
        bus.s_axil_awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [DW-1:0] dat, input logic [SW-1:0] s, input int d);
        bit hs;
        int n;
        repeat (d) @(posedge clk);
        if (d != 0) #1;
        bus.s_axil_wdata  = dat;
        bus.s_axil_wstrb  = s;
        bus.s_axil_wvalid = 1'b1;
        hs = 1'b0;
        n  = 0;
        while (!hs && n < 200) begin
            @(negedge clk);
            hs = bus.s_axil_wready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!hs) flag("W handshake timeout");
        bus.s_axil_wvalid = 1'b0;
    endtask

    task automatic do_write(input wr_t w, input int d_aw, input int d_w);
        exp_wr.push_back(w);
        fork
            send_aw(w.addr, d_aw);
            send_w(w.data, w.strb, d_w);
        join
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_wr.size() != 0 || exp_win.size() != 0 || exp_b.size() != 0 || in_win)
               && n < 3000) begin
            @(posedge clk);
            n++;
        end
        if (n >= 3000) flag("drain timeout");
        @(posedge clk);
        #1;
    endtask

    initial begin
        wr_t w;
        int n;
        bus.s_axil_awaddr  = '0;
        bus.s_axil_awprot  = '0;
        bus.s_axil_awvalid = 1'b0;
        bus.s_axil_wdata   = '0;
        bus.s_axil_wstrb   = '0;
        bus.s_axil_wvalid  = 1'b0;
        bus.s_axil_bready  = 1'b1;
        bus.reg_wr_ack     = 1'b0;
        bus.reg_wr_wait    = 1'b0;
        #1;
        check("reset reg_wr_en", 64'(bus.reg_wr_en), 64'd0);
        check("reset bvalid", 64'(bus.s_axil_bvalid), 64'd0);
        check("reset bresp", 64'(bus.s_axil_bresp), 64'd0);
        #21;
        rst = 1'b0;
        @(negedge clk);
        check("post-reset awready", 64'(bus.s_axil_awready), 64'd1);
        check("post-reset wready", 64'(bus.s_axil_wready), 64'd1);
        @(posedge clk);
        #1;

        w.addr = AW'(40'h10);
        w.data = 32'hDEADBEEF;
        w.strb = 4'hF;
        do_write(w, 0, 0);
        w.addr = AW'(40'h20);
        w.data = 32'h5;
        w.strb = 4'h3;
        do_write(w, 0, 3);
        w.addr = AW'(40'h30);
        w.data = 32'h1234;
        w.strb = 4'h0;
        do_write(w, 2, 0);

        for (int i = 0; i < int'(NWR); i++) begin
            w.addr = AW'({$urandom(), $urandom()});
            w.data = $urandom();
            w.strb = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            do_write(w, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        end
        drain();

        // Reset while a write is stuck waiting for its timeout.
        force_to = 1'b1;
        w.addr = AW'(40'hAB);
        w.data = 32'hCAFEF00D;
        w.strb = 4'hC;
        do_write(w, 0, 0);
        n = 0;
        while (!bus.reg_wr_en && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!bus.reg_wr_en) flag("reg_wr_en never rose before reset");
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("async reset reg_wr_en", 64'(bus.reg_wr_en), 64'd0);
        check("async reset bvalid", 64'(bus.s_axil_bvalid), 64'd0);
        check("async reset bresp", 64'(bus.s_axil_bresp), 64'd0);
        exp_wr.delete();
        exp_win.delete();
        exp_b.delete();
        force_to = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
        @(negedge clk);
        check("after reset awready", 64'(bus.s_axil_awready), 64'd1);
        check("after reset wready", 64'(bus.s_axil_wready), 64'd1);
        repeat (12) @(posedge clk);
        #1;
        check("no stray B after reset", 64'(bus.s_axil_bvalid), 64'd0);

        w.addr = AW'(40'h44);
        w.data = 32'h600D;
        w.strb = 4'h1;
        do_write(w, 0, 1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
